d16_wb_arbiter: RTL and testbench
=================================

Name: d16_wb_arbiter

Overview:
- Shares the single write port (addr_w/w/data) of d16_registers between N writeback requesters: ALU, load/store unit, debug.
- Round-robin arbitration, one write per cycle, registered outputs drive the register file directly.
- Keeps a 16-bit pending scoreboard (reserved at issue, cleared at commit) that decode uses to stall on RAW/WAW hazards.

Parameters:
- N, 3, number of write requesters (2..4); index 0 = ALU, 1 = LSU, 2 = debug.
- AW, 4, register address width (16 registers).
- DW, 16, data width.

Ports:
- sys_clk  in  1  system clock; all state updates on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- req  in  N  requester i holds a write pending; held until its ack.
- req_addr  in  N*AW  flattened target register, slice i = [AW*i +: AW].
- req_data  in  N*DW  flattened write data, slice i = [DW*i +: DW].
- ack  out  N  one-cycle pulse: requester i's write has been issued.
- rsv  in  1  decode reserves rsv_addr for a future write.
- rsv_addr  in  AW  register to reserve.
- rsv_stall  out  1  combinational: rsv_addr is pending; rsv is ignored this cycle.
- pending  out  16  scoreboard, bit r = register r awaiting writeback.
- rf_addr_w  out  AW  to d16_registers.addr_w.
- rf_w  out  1  to d16_registers.w.
- rf_data  out  DW  to d16_registers.data.

Behaviour:
- Reset (sync, sys_rst=1 at edge): ack=0, rf_w=0, rf_addr_w=0, rf_data=0, pending=0, last-grant pointer=N-1 (requester 0 wins first). Reset overrides every in-flight request; requesters re-present after reset.
- Eligibility: eligible[i] = req[i] & ~ack[i]. A requester whose ack is high this cycle is masked. This prevents double-granting a request that is still held during its ack cycle.
- Arbitration (combinational): scan from last+1 modulo N; first eligible index wins.
- Issue edge (any eligible): rf_addr_w/rf_data <= winner's slice; rf_w <= 1; ack[winner] <= 1, other acks 0; last <= winner.
- No eligible requester: rf_w <= 0, ack <= 0; rf_addr_w/rf_data hold their values.
- Latency: req seen at edge k; rf_w and ack high during cycle k+1; register file captures at edge k+2; qa/qb reflect new value after edge k+2.
- Throughput: one write per cycle sustained; with all N requesting continuously, each is granted exactly once per N cycles.
- Requester contract: on ack, either drop req or present the next write by the following edge. Addr/data must be stable while req is high and ack is low.
- Scoreboard:
  - Set: pending[rsv_addr] <= 1 at an edge with rsv=1 and rsv_stall=0.
  - Clear: pending[rf_addr_w] <= 0 at an edge with rf_w=1, i.e. the edge where the register file commits.
  - Simultaneous set and clear of the same register: set wins (a new reservation follows the commit).
  - Writes to non-pending registers (debug) are legal and leave pending unchanged.
- rsv_stall = rsv & pending[rsv_addr]; purely combinational, no state change.
- Register 0 is treated like any other register: no hardwired zero.

Decomposition:
- Shared package d16_pkg: D16_AW=4, D16_DW=16, D16_NREGS=16, requester index constants WB_ALU=0, WB_LSU=1, WB_DBG=2.
- One natural sub-module: d16_rr_arbiter (N-way round-robin, inputs eligible[N] and last, outputs one-hot grant and index). The scoreboard stays inline.
- Top-level test instance pairs d16_wb_arbiter with d16_registers.

Test Plan:
- Reset: assert sys_rst 2 cycles with req=3'b111 -> ack=0, rf_w=0, pending=0 throughout; first grant after release goes to requester 0.
- Single write: req[1]=1, addr=5, data=16'hBEEF -> ack[1] pulses 1 cycle one edge later with rf_w=1, rf_addr_w=5; qa at addr_a=5 reads 16'hBEEF two edges after req; no second ack while req is held.
- Round-robin: req=3'b111 held, each dropping after its ack -> grant order 0,1,2. Then hold all three continuously -> repeating 0,1,2,0,1,2 with rf_w high every cycle.
- Scoreboard: rsv addr 7 -> pending=16'h0080. A second rsv of 7 -> rsv_stall=1 and pending unchanged. ALU write to 7 -> pending=0 at the rf_w edge.
- Same-edge set/clear: rf_w issuing addr 3 while rsv addr 3 with pending[3]=0 -> pending[3]=1 afterwards.
- Reset mid-operation: sys_rst during the ack cycle of a write to 9 with pending[9]=1 -> next cycle rf_w=0, ack=0, pending=0.

Source files
------------

// File: rtl/d16_pkg.sv
// Shared constants for the d16 core: register file geometry and writeback
// requester indices.
package d16_pkg;

  localparam int D16_AW    = 4;
  localparam int D16_DW    = 16;
  localparam int D16_NREGS = 16;

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_DBG = 2;

endpackage

// File: rtl/d16_rr_arbiter.sv
// N-way round-robin picker: starting just after the last winner, the first
// eligible requester is granted. Purely combinational.
module d16_rr_arbiter #(
  parameter int N  = 3,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [LW-1:0] index,
  output logic          valid
);

  always_comb begin
    int j;
    grant = '0;
    index = '0;
    valid = 1'b0;
    j     = 0;
    for (int off = 1; off <= N; off++) begin
      j = int'(last) + off;
      if (j >= N) j = j - N;
      if (!valid && eligible[j[LW-1:0]]) begin
        valid             = 1'b1;
        grant[j[LW-1:0]]  = 1'b1;
        index             = j[LW-1:0];
      end
    end
  end

endmodule

// File: rtl/d16_wb_arbiter.sv
// Writeback arbiter for the d16 register file: round-robin over the write
// requesters, registered write port, plus the RAW/WAW pending scoreboard.
module d16_wb_arbiter
  import d16_pkg::*;
#(
  parameter int N  = 3,
  parameter int AW = D16_AW,
  parameter int DW = D16_DW
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [N-1:0]         req,
  input  logic [N*AW-1:0]      req_addr,
  input  logic [N*DW-1:0]      req_data,
  output logic [N-1:0]         ack,
  input  logic                 rsv,
  input  logic [AW-1:0]        rsv_addr,
  output logic                 rsv_stall,
  output logic [D16_NREGS-1:0] pending,
  output logic [AW-1:0]        rf_addr_w,
  output logic                 rf_w,
  output logic [DW-1:0]        rf_data
);

  localparam int LW = $clog2(N);

  logic [LW-1:0]        last;
  logic [N-1:0]         eligible;
  logic [N-1:0]         grant;
  logic [LW-1:0]        win_idx;
  logic                 win_valid;
  logic [D16_NREGS-1:0] pending_nxt;

  // A requester still holding req during its ack cycle must not win again.
  assign eligible  = req & ~ack;
  assign rsv_stall = rsv & pending[rsv_addr];

  d16_rr_arbiter #(.N(N), .LW(LW)) u_rr (
    .eligible (eligible),
    .last     (last),
    .grant    (grant),
    .index    (win_idx),
    .valid    (win_valid)
  );

  // Commit clears first, then a fresh reservation may set the same bit again.
  always_comb begin
    pending_nxt = pending;
    if (rf_w) pending_nxt[rf_addr_w] = 1'b0;
    if (rsv && !rsv_stall) pending_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ack       <= '0;
      rf_w      <= 1'b0;
      rf_addr_w <= '0;
      rf_data   <= '0;
      pending   <= '0;
      last      <= LW'(N - 1);
    end else begin
      pending <= pending_nxt;
      ack     <= grant;
      rf_w    <= win_valid;
      if (win_valid) begin
        rf_addr_w <= req_addr[AW*win_idx +: AW];
        rf_data   <= req_data[DW*win_idx +: DW];
        last      <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_d16_wb_arbiter.sv
// Directed bench for d16_wb_arbiter: a cycle table for round-robin and
// scoreboard behaviour, plus hand-written reset and hazard sequences.
module tb_d16_wb_arbiter;
  import d16_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [2:0]  req;
  logic [11:0] req_addr;
  logic [47:0] req_data;
  logic [2:0]  ack;
  logic        rsv;
  logic [3:0]  rsv_addr;
  logic        rsv_stall;
  logic [15:0] pending;
  logic [3:0]  rf_addr_w;
  logic        rf_w;
  logic [15:0] rf_data;

  logic [3:0]  addr_s [3];
  logic [15:0] data_s [3];
  logic [15:0] rf_mem [16];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  req;
    logic        rsv;
    logic [3:0]  rsv_addr;
    logic        exp_stall;
    logic [2:0]  exp_ack;
    logic        exp_rf_w;
    logic [3:0]  exp_addr;
    logic [15:0] exp_pending;
  } vec_t;

  vec_t vecs [8];

  assign req_addr = {addr_s[2], addr_s[1], addr_s[0]};
  assign req_data = {data_s[2], data_s[1], data_s[0]};

  always #5 sys_clk = ~sys_clk;

  // Stand-in for d16_registers: captures on the edge where rf_w is high.
  always @(posedge sys_clk) if (rf_w) rf_mem[rf_addr_w] <= rf_data;

  d16_wb_arbiter #(.N(3), .AW(4), .DW(16)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .ack       (ack),
    .rsv       (rsv),
    .rsv_addr  (rsv_addr),
    .rsv_stall (rsv_stall),
    .pending   (pending),
    .rf_addr_w (rf_addr_w),
    .rf_w      (rf_w),
    .rf_data   (rf_data)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [2:0] r, input logic rv, input logic [3:0] ra);
    req      = r;
    rsv      = rv;
    rsv_addr = ra;
  endtask

  task automatic restore_sources();
    addr_s[WB_ALU] = 4'd1; data_s[WB_ALU] = 16'h1111;
    addr_s[WB_LSU] = 4'd2; data_s[WB_LSU] = 16'h2222;
    addr_s[WB_DBG] = 4'd3; data_s[WB_DBG] = 16'h3333;
  endtask

  initial begin
    //              req     rsv  addr  stall ack     rf_w  addr   pending
    vecs[0] = '{3'b111, 1'b1, 4'd5, 1'b0, 3'b001, 1'b1, 4'd1, 16'h0020};
    vecs[1] = '{3'b111, 1'b0, 4'd0, 1'b0, 3'b010, 1'b1, 4'd2, 16'h0020};
    vecs[2] = '{3'b111, 1'b1, 4'd2, 1'b0, 3'b100, 1'b1, 4'd3, 16'h0024};
    vecs[3] = '{3'b111, 1'b0, 4'd0, 1'b0, 3'b001, 1'b1, 4'd1, 16'h0024};
    vecs[4] = '{3'b111, 1'b0, 4'd0, 1'b0, 3'b010, 1'b1, 4'd2, 16'h0024};
    vecs[5] = '{3'b111, 1'b0, 4'd0, 1'b0, 3'b100, 1'b1, 4'd3, 16'h0020};
    vecs[6] = '{3'b000, 1'b0, 4'd0, 1'b0, 3'b000, 1'b0, 4'd3, 16'h0020};
    vecs[7] = '{3'b000, 1'b1, 4'd5, 1'b1, 3'b000, 1'b0, 4'd3, 16'h0020};

    restore_sources();
    sys_rst = 1'b1;
    apply_stimulus(3'b111, 1'b0, 4'd0);

    for (int c = 0; c < 2; c++) begin
      tick();
      check_output($sformatf("rst%0d_ack", c), 32'(ack), 32'h0);
      check_output($sformatf("rst%0d_rf_w", c), 32'(rf_w), 32'h0);
      check_output($sformatf("rst%0d_pending", c), 32'(pending), 32'h0);
    end
    sys_rst = 1'b0;

    // Round-robin with all requesters held, scoreboard running alongside.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].req, vecs[i].rsv, vecs[i].rsv_addr);
      #1;
      check_output($sformatf("vec%0d_stall", i), 32'(rsv_stall), 32'(vecs[i].exp_stall));
      tick();
      check_output($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
      check_output($sformatf("vec%0d_rf_w", i), 32'(rf_w), 32'(vecs[i].exp_rf_w));
      check_output($sformatf("vec%0d_addr", i), 32'(rf_addr_w), 32'(vecs[i].exp_addr));
      check_output($sformatf("vec%0d_data", i), 32'(rf_data), 32'({4{vecs[i].exp_addr}}));
      check_output($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].exp_pending));
    end

    // Single LSU write to a pending register, req held through the ack cycle.
    addr_s[WB_LSU] = 4'd5; data_s[WB_LSU] = 16'hBEEF;
    apply_stimulus(3'b010, 1'b0, 4'd0);
    tick();
    check_output("single_ack", 32'(ack), 32'h2);
    check_output("single_rf_w", 32'(rf_w), 32'h1);
    check_output("single_addr", 32'(rf_addr_w), 32'h5);
    check_output("single_data", 32'(rf_data), 32'hBEEF);
    tick();
    check_output("single_no_reack", 32'(ack), 32'h0);
    check_output("single_rf_w_low", 32'(rf_w), 32'h0);
    check_output("single_rf_mem5", 32'(rf_mem[5]), 32'hBEEF);
    check_output("single_pending_clr", 32'(pending), 32'h0);
    apply_stimulus(3'b000, 1'b0, 4'd0);

    // Reserve r7, retry the reservation, then commit it from the ALU.
    apply_stimulus(3'b000, 1'b1, 4'd7);
    #1;
    check_output("rsv7_stall0", 32'(rsv_stall), 32'h0);
    tick();
    check_output("rsv7_pending", 32'(pending), 32'h0080);
    #1;
    check_output("rsv7_stall1", 32'(rsv_stall), 32'h1);
    tick();
    check_output("rsv7_pending_hold", 32'(pending), 32'h0080);
    addr_s[WB_ALU] = 4'd7; data_s[WB_ALU] = 16'h7777;
    apply_stimulus(3'b001, 1'b0, 4'd0);
    tick();
    check_output("alu7_ack", 32'(ack), 32'h1);
    check_output("alu7_addr", 32'(rf_addr_w), 32'h7);
    check_output("alu7_pending_pre", 32'(pending), 32'h0080);
    apply_stimulus(3'b000, 1'b0, 4'd0);
    tick();
    check_output("alu7_pending_clr", 32'(pending), 32'h0);
    check_output("alu7_rf_mem7", 32'(rf_mem[7]), 32'h7777);

    // Commit and reservation of r3 on the same edge: reservation survives.
    addr_s[WB_ALU] = 4'd3; data_s[WB_ALU] = 16'h0333;
    apply_stimulus(3'b001, 1'b0, 4'd0);
    tick();
    check_output("same_ack", 32'(ack), 32'h1);
    check_output("same_addr", 32'(rf_addr_w), 32'h3);
    apply_stimulus(3'b000, 1'b1, 4'd3);
    #1;
    check_output("same_stall", 32'(rsv_stall), 32'h0);
    tick();
    check_output("same_pending", 32'(pending), 32'h0008);

    // Reset lands during the ack cycle of a write to pending r9.
    apply_stimulus(3'b000, 1'b1, 4'd9);
    tick();
    check_output("mid_pending", 32'(pending), 32'h0208);
    addr_s[WB_LSU] = 4'd9; data_s[WB_LSU] = 16'h9999;
    apply_stimulus(3'b010, 1'b0, 4'd0);
    tick();
    check_output("mid_ack", 32'(ack), 32'h2);
    check_output("mid_addr", 32'(rf_addr_w), 32'h9);
    sys_rst = 1'b1;
    apply_stimulus(3'b000, 1'b0, 4'd0);
    tick();
    check_output("mid_rst_ack", 32'(ack), 32'h0);
    check_output("mid_rst_rf_w", 32'(rf_w), 32'h0);
    check_output("mid_rst_pending", 32'(pending), 32'h0);
    check_output("mid_rst_addr", 32'(rf_addr_w), 32'h0);
    sys_rst = 1'b0;

    // Pointer is back to N-1, so requester 0 wins first again.
    restore_sources();
    apply_stimulus(3'b111, 1'b0, 4'd0);
    tick();
    check_output("post_rst_ack", 32'(ack), 32'h1);
    check_output("post_rst_addr", 32'(rf_addr_w), 32'h1);
    apply_stimulus(3'b000, 1'b0, 4'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
